// File: rtl/eggtimer_pkg.sv
// Shared constants for the egg-timer display: active-low segment patterns
// ({g,f,e,d,c,b,a}) and the scan-slot digit indices.
package eggtimer_pkg;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   localparam logic [1:0] IDX_S1  = 2'd0;
   localparam logic [1:0] IDX_S10 = 2'd1;
   localparam logic [1:0] IDX_M1  = 2'd2;
   localparam logic [1:0] IDX_M10 = 2'd3;

   localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
   import eggtimer_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/eggtimer_display.sv
// Four-digit multiplexed MM.SS display with frame snapshots and blink on expiry.
// Optional EGGTIMER_LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it is 0.
module eggtimer_display
   import eggtimer_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_TICKS = 250
) (
   input  logic       CLK100MHZ,
   input  logic       rst,
   input  logic [3:0] m10,
   input  logic [3:0] m1,
   input  logic [3:0] s10,
   input  logic [3:0] s1,
   input  logic       zero,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

`ifdef EGGTIMER_LEADING_ZERO_BLANK_EN
   localparam bit LEAD_BLANK = 1'b1;
`else
   localparam bit LEAD_BLANK = 1'b0;
`endif

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    digit_in [4];
   logic [3:0]    snap_q [4];
   logic          zero_meta_q, zero_s_q;
   logic [BW-1:0] blink_cnt_q;
   logic          phase_q;
   logic [6:0]    seg_dec;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);
   assign idx_d = tick ? idx_q + 2'd1 : idx_q;

   assign digit_in[IDX_S1]  = s1;
   assign digit_in[IDX_S10] = s10;
   assign digit_in[IDX_M1]  = m1;
   assign digit_in[IDX_M10] = m10;

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // Capture on the last slot's tick so the next frame starts with a fresh, coherent set.
   always_ff @(posedge CLK100MHZ) begin
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            snap_q[i] <= '0;
         end else if (tick && idx_q == IDX_M10) begin
            snap_q[i] <= digit_in[i];
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         zero_meta_q <= 1'b0;
         zero_s_q    <= 1'b0;
      end else begin
         zero_meta_q <= zero;
         zero_s_q    <= zero_meta_q;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst || !zero_s_q) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
         end
      end
   end

   bcd_to_seg u_dec (
      .bcd_i (snap_q[idx_q]),
      .seg_o (seg_dec)
   );

   always_comb begin
      an_d        = AN_OFF;
      an_d[idx_q] = 1'b0;
      seg_d       = seg_dec;
      dp_d        = (idx_q == IDX_M1) ? 1'b0 : 1'b1;
      if (LEAD_BLANK && idx_q == IDX_M10 && snap_q[IDX_M10] == 4'd0) begin
         an_d = AN_OFF;
      end
      // zero_s gates the blank so a falling zero unblanks before phase_q clears.
      if (zero_s_q && phase_q) begin
         an_d = AN_OFF;
         dp_d = 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
